// File: rtl/tbs_uart_rx.sv
// UART 8N1 receiver (8E1 when UART_RX_PARITY_EN is defined) feeding a byte-wide valid/ready sink.
// Latency: valid_o rises one clock after the stop-bit sample; rx_i adds SYNC_STAGES clocks of sync delay.
// Backpressure: one-byte holding register; a byte completing while it is full and not drained is dropped with overrun_o.
module tbs_uart_rx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       busy_o,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       parity_err_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd5;
`endif

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_prev;
    logic [2:0]             r_state;
    logic [CW-1:0]          r_baud;
    logic [2:0]             r_bit_cnt;
    logic [7:0]             r_shift;
    logic [7:0]             r_data;
    logic                   r_valid;
    logic                   r_frame_err;
    logic                   r_overrun;
`ifdef UART_RX_PARITY_EN
    logic                   r_par_bit;
    logic                   r_parity_err;
`endif

    logic w_rx_s;
    logic w_baud_last;
    logic w_stop_sample;
    logic w_par_bad;
    logic w_complete;

    assign w_rx_s        = r_sync[SYNC_STAGES-1];
    assign w_baud_last   = (r_baud == C_LAST);
    assign w_stop_sample = (r_state == S_STOP) && w_baud_last;
`ifdef UART_RX_PARITY_EN
    // Even parity: XOR over data bits plus the received parity bit must be 0.
    assign w_par_bad     = ^{r_shift, r_par_bit};
`else
    assign w_par_bad     = 1'b0;
`endif
    // A byte is delivered only with a good stop bit and (if enabled) good parity.
    assign w_complete    = w_stop_sample && w_rx_s && !w_par_bad;

    // Metastability synchronizer plus one delayed copy for falling-edge detection; idle-high reset.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_sync    <= '1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], rx_i};
            r_rx_prev <= w_rx_s;
        end
    end

    // Frame state machine: start qualification at half bit, then one sample per bit centre.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
`ifdef UART_RX_PARITY_EN
            r_par_bit <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_baud    <= '0;
                    r_bit_cnt <= 3'd0;
                    if (r_rx_prev && !w_rx_s) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_baud == C_HALF) begin
                        // Restart the count here so every later sample lands one full bit later.
                        r_baud  <= '0;
                        r_state <= w_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_baud_last) begin
                        r_baud    <= '0;
                        r_shift   <= {w_rx_s, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_baud_last) begin
                        r_baud    <= '0;
                        r_par_bit <= w_rx_s;
                        r_state   <= S_STOP;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_baud_last) begin
                        // Leaving at the stop-bit centre lets a start bit be caught in its second half.
                        r_baud  <= '0;
                        r_state <= w_rx_s ? S_IDLE : S_WAIT;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_WAIT: begin
                    // Hold off through a break until the line returns high.
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Holding register, handshake and one-cycle error pulses.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_stop_sample && !w_rx_s;
            r_overrun   <= w_complete && r_valid && !ready_i;
            if (w_complete && (!r_valid || ready_i)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity mismatch pulse, reported alongside the stop-bit sample.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_stop_sample && w_par_bad;
        end
    end
    assign parity_err_o = r_parity_err;
`else
    assign parity_err_o = 1'b0;
`endif

    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign busy_o      = (r_state != S_IDLE);
    assign frame_err_o = r_frame_err;
    assign overrun_o   = r_overrun;

endmodule

// File: tb/tb_tbs_uart_rx.sv
// Bench for tbs_uart_rx at CLKS_PER_BIT=8: directed frames, expected bytes queued, monitor compares transfers.
// Latency: driven by bit-serial stimulus; pulse counts compared per test.
// Backpressure: ready_i toggled by the stimulus to exercise hold and overrun.
module tb_tbs_uart_rx;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       rdy = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       ferr;
    logic       ovr;
    logic       perr;

    int checks = 0;
    int errors = 0;
    int n_ferr = 0;
    int n_ovr  = 0;
    int n_perr = 0;
    int bf, bo, bp;

    logic [7:0] exp_q[$];
    logic       hold_vld = 1'b0;
    logic [7:0] hold_dat = 8'h00;

    tbs_uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .clock_i      (clk),
        .reset_i      (rst),
        .rx_i         (rx),
        .data_o       (data),
        .valid_o      (valid),
        .ready_i      (rdy),
        .busy_o       (busy),
        .frame_err_o  (ferr),
        .overrun_o    (ovr),
        .parity_err_o (perr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: pulse counting, hold stability and scoreboard pop on each transfer.
    always @(negedge clk) begin
        if (rst) begin
            hold_vld = 1'b0;
        end else begin
            if (ferr) n_ferr++;
            if (ovr)  n_ovr++;
            if (perr) n_perr++;
            if (hold_vld) begin
                checks++;
                if (valid !== 1'b1 || data !== hold_dat) begin
                    errors++;
                    $display("FAIL hold_stable valid=%0b data=%0h required valid=1 data=%0h", valid, data, hold_dat);
                end
            end
            if (valid && rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_transfer data=%0h required no transfer", data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (data !== e) begin
                        errors++;
                        $display("FAIL transfer_data actual=%0h required=%0h", data, e);
                    end
                end
            end
            hold_vld = valid && !rdy;
            hold_dat = data;
        end
    end

    task automatic send_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_bits);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^d);
`endif
        for (int i = 0; i < stop_bits; i++) send_bit(stop_v);
        rx = 1'b1;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_bad_parity(input logic [7:0] d);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(~(^d));
        send_bit(1'b1);
        rx = 1'b1;
    endtask
`endif

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        chk({tag, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic snap();
        bf = n_ferr;
        bo = n_ovr;
        bp = n_perr;
    endtask

    task automatic pulses(input string tag, input int ef, input int eo, input int ep);
        chk({tag, "_frame_err_cnt"},  n_ferr - bf, ef);
        chk({tag, "_overrun_cnt"},    n_ovr - bo, eo);
        chk({tag, "_parity_err_cnt"}, n_perr - bp, ep);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rx = 1'b1; rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", valid, 0);
        chk("reset_data",  data,  0);
        chk("reset_busy",  busy,  0);
        chk("reset_ferr",  ferr,  0);
        chk("reset_ovr",   ovr,   0);
        chk("reset_perr",  perr,  0);
        @(posedge clk);
        rst = 1'b0;
        idle_bits(2);

        // Single byte with ready high; busy sampled mid-frame.
        snap();
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1, 1);
            begin
                repeat (3 * CPB) @(posedge clk);
                #1 chk("busy_mid_frame", busy, 1);
            end
        join
        idle_bits(2);
        drain("a5");
        chk("busy_after_frame", busy, 0);
        pulses("a5", 0, 0, 0);

        // Back-to-back frames with no idle gap.
        snap();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1, 1);
        send_frame(8'hFF, 1'b1, 1);
        idle_bits(2);
        drain("b2b");
        pulses("b2b", 0, 0, 0);

        // Glitch shorter than half a bit.
        snap();
        rx = 1'b0;
        repeat (3) @(posedge clk);
        rx = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("busy_false_start", busy, 1);
        repeat (12) @(posedge clk);
        #1 chk("busy_after_false_start", busy, 0);
        chk("valid_after_false_start", valid, 0);
        pulses("glitch", 0, 0, 0);

        // Stop bit held low for two bit times, then a good frame.
        snap();
        send_frame(8'h3C, 1'b0, 2);
        idle_bits(2);
        chk("valid_after_frame_err", valid, 0);
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1);
        idle_bits(2);
        drain("ferr");
        pulses("ferr", 1, 0, 0);

        // Overrun while the sink stalls.
        snap();
        rdy = 1'b0;
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1, 1);
        idle_bits(1);
        #1 chk("held_valid", valid, 1);
        chk("held_data_first", data, 8'h12);
        send_frame(8'h34, 1'b1, 1);
        idle_bits(2);
        #1 chk("held_data_after_overrun", data, 8'h12);
        rdy = 1'b1;
        drain("ovr");
        repeat (3) @(posedge clk);
        #1 chk("valid_after_drain", valid, 0);
        pulses("ovr", 0, 1, 0);

        // Reset mid-DATA with a byte still held.
        snap();
        rdy = 1'b0;
        send_frame(8'h77, 1'b1, 1);
        idle_bits(1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #1 rst = 1'b1;
        #1;
        chk("midreset_valid", valid, 0);
        chk("midreset_data",  data,  0);
        chk("midreset_busy",  busy,  0);
        rx = 1'b1;
        repeat (2) @(posedge clk);
        rst = 1'b0;
        rdy = 1'b1;
        idle_bits(2);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1);
        idle_bits(2);
        drain("after_reset");
        pulses("reset", 0, 0, 0);

`ifdef UART_RX_PARITY_EN
        // Wrong parity: pulse, no byte delivered.
        snap();
        send_bad_parity(8'h5A);
        idle_bits(2);
        chk("valid_after_parity_err", valid, 0);
        pulses("parity", 0, 0, 1);
`endif

        chk("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
